// File: rtl/synth_pkg.sv
// Shared types and constants for the synth audio datapath.
// Sample and coefficient formats, output clamp limits and the tap
// accumulator state encoding live here so every stage agrees on them.
package synth_pkg;

    localparam int SAMPLE_W  = 24;
    localparam int PRODUCT_W = 2 * SAMPLE_W;

    // Signed two's-complement audio sample.
    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // Signed Q1.23 filter coefficient.
    typedef logic signed [SAMPLE_W-1:0] coeff_t;

    localparam sample_t SAMPLE_MAX = 24'sh7FFFFF;
    localparam sample_t SAMPLE_MIN = 24'sh800000;

    // Frame sequencing states of the tap accumulator.
    typedef enum logic [1:0] {
        TAP_IDLE  = 2'd0,
        TAP_RUN   = 2'd1,
        TAP_FLUSH = 2'd2
    } tap_acc_state_t;

endpackage : synth_pkg

// File: rtl/fir_tap_accumulator_if.sv
// Tap/result bus between the memory-sequenced FIR filter and the
// multiply-accumulate stage. The filter side is the master: it supplies
// sample/coefficient pairs and receives the finished output sample.
interface fir_tap_accumulator_if;
    import synth_pkg::*;

    sample_t SampleIn;
    coeff_t  CoeffIn;
    logic    TapValid;
    logic    TapFirst;

    sample_t WaveOut;
    logic    WaveValid;
    logic    Saturated;
    logic    FrameError;

    modport master (
        output SampleIn,
        output CoeffIn,
        output TapValid,
        output TapFirst,
        input  WaveOut,
        input  WaveValid,
        input  Saturated,
        input  FrameError
    );

    modport slave (
        input  SampleIn,
        input  CoeffIn,
        input  TapValid,
        input  TapFirst,
        output WaveOut,
        output WaveValid,
        output Saturated,
        output FrameError
    );

endinterface : fir_tap_accumulator_if

// File: rtl/round_saturate.sv
// Converts a wide fixed-point accumulator back to a 24-bit sample:
// round half up at the coefficient binary point, then clamp to the
// sample range. Purely combinational; the caller registers the result.
module round_saturate
    import synth_pkg::*;
#(
    parameter int ACC_W      = 56,
    parameter int COEFF_FRAC = 23
) (
    input  logic signed [ACC_W-1:0] accIn,
    output sample_t                 result,
    output logic                    clipped
);

    // Half an LSB of the output, added before the arithmetic shift.
    localparam logic signed [ACC_W-1:0] ROUND_BIAS = ACC_W'(64'sd1 <<< (COEFF_FRAC - 1));
    localparam logic signed [ACC_W-1:0] SAT_HI     = ACC_W'(SAMPLE_MAX);
    localparam logic signed [ACC_W-1:0] SAT_LO     = ACC_W'(SAMPLE_MIN);

    logic signed [ACC_W-1:0] biased;
    logic signed [ACC_W-1:0] shifted;

    // Round, shift down to sample scale and clamp to the 24-bit range.
    always_comb begin
        biased  = accIn + ROUND_BIAS;
        shifted = biased >>> COEFF_FRAC;
        result  = shifted[SAMPLE_W-1:0];
        clipped = 1'b0;
        if (shifted > SAT_HI) begin
            result  = SAMPLE_MAX;
            clipped = 1'b1;
        end else if (shifted < SAT_LO) begin
            result  = SAMPLE_MIN;
            clipped = 1'b1;
        end
    end

endmodule : round_saturate

// File: rtl/fir_tap_accumulator.sv
// Multiply-accumulate stage behind the FIR filter. Accepts one
// sample/coefficient pair per tap, accumulates a frame of TAPS products
// through a three-stage pipeline and emits one rounded, saturated sample
// per frame. A frame-sequencing FSM decides which taps are accepted and
// flags malformed frames; per-tap first/last markers travel down the
// pipeline so overlapping frames drain independently.
module fir_tap_accumulator
    import synth_pkg::*;
#(
    parameter int TAPS       = 256,
    parameter int COEFF_FRAC = 23,
    parameter int ACC_W      = 56
) (
    input  logic                 Clock,
    input  logic                 Reset,
    fir_tap_accumulator_if.slave tapBus
);

    localparam int              CNT_W      = $clog2(TAPS) + 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TAPS - 1);
    localparam logic            SINGLE_TAP = (TAPS == 1);

    // Frame sequencing.
    tap_acc_state_t   state;
    logic [CNT_W-1:0] tapCount;
    logic             flushCount;
    logic             frameError;

    // Acceptance decisions for the tap presented this cycle.
    logic tapStart;
    logic tapAccept;
    logic tapFirstAcc;
    logic tapLastAcc;
    logic tapError;

    // Pipeline stage 1: operands.
    sample_t p1Sample;
    coeff_t  p1Coeff;
    logic    p1Valid;
    logic    p1First;
    logic    p1Last;

    // Pipeline stage 2: product.
    logic signed [PRODUCT_W-1:0] p2Product;
    logic                        p2Valid;
    logic                        p2First;
    logic                        p2Last;
    logic signed [ACC_W-1:0]     productExt;

    // Pipeline stage 3: accumulator.
    logic signed [ACC_W-1:0] acc;
    logic                    accLast;

    // Output registers.
    sample_t rsResult;
    logic    rsClipped;
    sample_t waveOut;
    logic    waveValid;
    logic    saturated;

    // Decide whether the current tap is taken, whether it opens or closes a frame, and whether it is an error.
    always_comb begin
        tapStart    = tapBus.TapValid & tapBus.TapFirst;
        tapAccept   = 1'b0;
        tapFirstAcc = 1'b0;
        tapError    = 1'b0;
        case (state)
            TAP_IDLE: begin
                tapAccept   = tapStart;
                tapFirstAcc = tapStart;
            end
            TAP_RUN: begin
                tapAccept   = tapBus.TapValid;
                tapFirstAcc = tapStart;
                tapError    = tapStart;
            end
            TAP_FLUSH: begin
                tapAccept   = tapStart;
                tapFirstAcc = tapStart;
                tapError    = tapBus.TapValid & ~tapBus.TapFirst;
            end
            default: begin
                tapAccept   = 1'b0;
            end
        endcase
        tapLastAcc = tapAccept & (tapFirstAcc ? SINGLE_TAP : (tapCount == LAST_COUNT));
    end

    // Frame FSM: counts accepted taps, holds two drain cycles after the last tap, registers the error pulse.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= TAP_IDLE;
            tapCount   <= '0;
            flushCount <= 1'b0;
            frameError <= 1'b0;
        end else begin
            frameError <= tapError;
            if (tapAccept) begin
                tapCount   <= tapFirstAcc ? CNT_W'(1) : tapCount + 1'b1;
                flushCount <= 1'b0;
                state      <= tapLastAcc ? TAP_FLUSH : TAP_RUN;
            end else if (state == TAP_FLUSH) begin
                if (flushCount) begin
                    state      <= TAP_IDLE;
                    tapCount   <= '0;
                    flushCount <= 1'b0;
                end else begin
                    flushCount <= 1'b1;
                end
            end
        end
    end

    // Stage 1: capture accepted operands together with their frame markers.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            p1Sample <= '0;
            p1Coeff  <= '0;
            p1Valid  <= 1'b0;
            p1First  <= 1'b0;
            p1Last   <= 1'b0;
        end else begin
            p1Valid <= tapAccept;
            p1First <= tapFirstAcc;
            p1Last  <= tapLastAcc;
            if (tapAccept) begin
                p1Sample <= tapBus.SampleIn;
                p1Coeff  <= tapBus.CoeffIn;
            end
        end
    end

    // Stage 2: full-precision signed product.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            p2Product <= '0;
            p2Valid   <= 1'b0;
            p2First   <= 1'b0;
            p2Last    <= 1'b0;
        end else begin
            p2Valid <= p1Valid;
            p2First <= p1First;
            p2Last  <= p1Valid & p1Last;
            if (p1Valid) begin
                p2Product <= PRODUCT_W'(p1Sample) * PRODUCT_W'(p1Coeff);
            end
        end
    end

    assign productExt = ACC_W'(p2Product);

    // Stage 3: the first tap of a frame loads the accumulator, later taps add to it.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            acc     <= '0;
            accLast <= 1'b0;
        end else begin
            accLast <= p2Valid & p2Last;
            if (p2Valid) begin
                acc <= p2First ? productExt : acc + productExt;
            end
        end
    end

    round_saturate #(
        .ACC_W      (ACC_W),
        .COEFF_FRAC (COEFF_FRAC)
    ) u_round_saturate (
        .accIn   (acc),
        .result  (rsResult),
        .clipped (rsClipped)
    );

    // Register the finished sample once the last product of a frame has been accumulated.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            waveOut   <= '0;
            waveValid <= 1'b0;
            saturated <= 1'b0;
        end else begin
            waveValid <= accLast;
            if (accLast) begin
                waveOut   <= rsResult;
                saturated <= rsClipped;
            end
        end
    end

    assign tapBus.WaveOut    = waveOut;
    assign tapBus.WaveValid  = waveValid;
    assign tapBus.Saturated  = saturated;
    assign tapBus.FrameError = frameError;

endmodule : fir_tap_accumulator

// File: tb/tb_fir_tap_accumulator.sv
// Scoreboard bench for fir_tap_accumulator with TAPS=4. A frame-level
// reference model turns every driven tap into expected outputs and
// expected error pulses; an independent monitor pops and compares them
// whenever the DUT presents WaveValid or FrameError.
module tb_fir_tap_accumulator;
    import synth_pkg::*;

    localparam int TAPS  = 4;
    localparam int CF    = 23;
    localparam int ACC_W = 56;

    logic Clock = 1'b0;
    logic Reset = 1'b0;

    fir_tap_accumulator_if bus();

    fir_tap_accumulator #(
        .TAPS       (TAPS),
        .COEFF_FRAC (CF),
        .ACC_W      (ACC_W)
    ) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .tapBus (bus)
    );

    always #5 Clock = ~Clock;

    int cycleCount = 0;
    always @(posedge Clock) cycleCount <= cycleCount + 1;

    int checks = 0;
    int passes = 0;

    typedef struct {
        sample_t value;
        logic    sat;
        int      cyc;
    } exp_t;

    exp_t outQ[$];
    int   errQ[$];

    // Reference model state: frame in progress, taps so far, running sum, edge of last completed frame.
    bit     mActive    = 1'b0;
    int     mCount     = 0;
    longint mSum       = 0;
    int     mDoneCycle = -100;

    sample_t fs[TAPS];
    coeff_t  fc[TAPS];

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    endtask

    // Reference model fed with each tap as sampled at posedge number cyc.
    task automatic modelTap(input bit v, input bit f, input sample_t s, input coeff_t c, input int cyc);
        longint prod;
        longint r;
        bit     sat;
        bit     inFlush;
        exp_t   e;
        prod    = longint'(s) * longint'(c);
        inFlush = ((cyc - mDoneCycle) == 1) || ((cyc - mDoneCycle) == 2);
        if (!v) return;
        if (mActive) begin
            if (f) begin
                errQ.push_back(cyc);
                mSum   = prod;
                mCount = 1;
            end else begin
                mSum   = mSum + prod;
                mCount = mCount + 1;
            end
        end else if (f) begin
            mActive = 1'b1;
            mSum    = prod;
            mCount  = 1;
        end else begin
            if (inFlush) errQ.push_back(cyc);
            return;
        end
        if (mCount == TAPS) begin
            r   = (mSum + (longint'(1) <<< (CF - 1))) >>> CF;
            sat = 1'b0;
            if (r > 8388607) begin
                r   = 8388607;
                sat = 1'b1;
            end else if (r < -8388608) begin
                r   = -8388608;
                sat = 1'b1;
            end
            e.value = r[23:0];
            e.sat   = sat;
            e.cyc   = cyc + 3;
            outQ.push_back(e);
            mActive    = 1'b0;
            mDoneCycle = cyc;
        end
    endtask

    // Drive one cycle of tap inputs (called at a falling edge), inform the model, advance to the next falling edge.
    task automatic step(input bit v, input bit f, input sample_t s, input coeff_t c);
        bus.TapValid = v;
        bus.TapFirst = f;
        bus.SampleIn = s;
        bus.CoeffIn  = c;
        modelTap(v, f, s, c, cycleCount + 1);
        @(negedge Clock);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 24'($urandom), 24'($urandom));
        end
    endtask

    task automatic sendFrame();
        for (int i = 0; i < TAPS; i++) step(1'b1, (i == 0), fs[i], fc[i]);
    endtask

    task automatic constFrame(input sample_t s, input coeff_t c);
        for (int i = 0; i < TAPS; i++) begin
            fs[i] = s;
            fc[i] = c;
        end
        sendFrame();
    endtask

    function automatic sample_t randSample();
        sample_t s;
        s = 24'($urandom);
        if ($urandom_range(0, 3) != 0) s = s >>> 4;
        return s;
    endfunction

    // Monitor: compare every output event against the front of the expectation queues.
    exp_t monE;
    int   monErr;
    always @(negedge Clock) begin
        if (Reset) begin
            if (bus.WaveValid) begin
                if (outQ.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_wave: WaveValid=1 WaveOut=0x%06h at cycle %0d, none required", bus.WaveOut, cycleCount);
                end else begin
                    monE = outQ.pop_front();
                    check("wave_out", longint'(bus.WaveOut), longint'(monE.value));
                    check("saturated", longint'(bus.Saturated), longint'(monE.sat));
                    check("wave_cycle", longint'(cycleCount), longint'(monE.cyc));
                    $display("wave cycle=%0d out=0x%06h sat=%0b", cycleCount, bus.WaveOut, bus.Saturated);
                end
            end
            if (bus.FrameError) begin
                if (errQ.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_frame_error: FrameError=1 at cycle %0d, none required", cycleCount);
                end else begin
                    monErr = errQ.pop_front();
                    check("frame_error_cycle", longint'(cycleCount), longint'(monErr));
                    $display("frame_error cycle=%0d", cycleCount);
                end
            end
        end
    end

    initial begin
        int mode;
        int n;
        bus.TapValid = 1'b0;
        bus.TapFirst = 1'b0;
        bus.SampleIn = '0;
        bus.CoeffIn  = '0;

        // Reset state.
        repeat (3) @(negedge Clock);
        check("reset_wave_out", longint'(bus.WaveOut), 0);
        check("reset_wave_valid", longint'(bus.WaveValid), 0);
        check("reset_saturated", longint'(bus.Saturated), 0);
        check("reset_frame_error", longint'(bus.FrameError), 0);
        Reset = 1'b1;
        @(negedge Clock);

        // Unity path, clips, rounding.
        constFrame(24'sh100000, 24'sh200000);
        idle(3);
        constFrame(24'sh7FFFFF, 24'sh7FFFFF);
        idle(2);
        constFrame(24'sh800000, 24'sh7FFFFF);
        idle(4);
        fs[0] = 24'sh000001; fc[0] = 24'sh400000;
        for (int i = 1; i < TAPS; i++) begin fs[i] = randSample(); fc[i] = '0; end
        sendFrame();
        idle(3);
        fs[0] = 24'shFFFFFF;
        sendFrame();
        idle(3);

        // Early TapFirst: two taps, then a full unity frame.
        step(1'b1, 1'b1, 24'sh100000, 24'sh200000);
        step(1'b1, 1'b0, 24'sh100000, 24'sh200000);
        constFrame(24'sh100000, 24'sh200000);
        idle(4);

        // Back-to-back frames.
        constFrame(24'sh100000, 24'sh200000);
        constFrame(24'sh080000, 24'sh200000);
        constFrame(24'shF00000, 24'sh200000);
        idle(6);

        // Reset mid-frame.
        step(1'b1, 1'b1, 24'sh100000, 24'sh200000);
        step(1'b1, 1'b0, 24'sh100000, 24'sh200000);
        bus.TapValid = 1'b0;
        Reset = 1'b0;
        #1;
        check("midreset_wave_out", longint'(bus.WaveOut), 0);
        check("midreset_wave_valid", longint'(bus.WaveValid), 0);
        check("midreset_saturated", longint'(bus.Saturated), 0);
        check("midreset_frame_error", longint'(bus.FrameError), 0);
        check("midreset_pending_outputs", longint'(outQ.size()), 0);
        outQ.delete();
        errQ.delete();
        mActive    = 1'b0;
        mCount     = 0;
        mSum       = 0;
        mDoneCycle = -100;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
        idle(1);
        constFrame(24'sh100000, 24'sh200000);
        idle(4);

        // Randomized traffic: full frames with gaps, partial frames, stray taps.
        for (int it = 0; it < 80; it++) begin
            mode = $urandom_range(0, 9);
            if (mode <= 5) begin
                for (int i = 0; i < TAPS; i++) begin fs[i] = randSample(); fc[i] = 24'($urandom); end
                sendFrame();
                idle($urandom_range(0, 3));
            end else if (mode == 6) begin
                n = $urandom_range(1, TAPS - 1);
                for (int i = 0; i < n; i++) step(1'b1, (i == 0), randSample(), 24'($urandom));
            end else if (mode == 7) begin
                step(1'b1, 1'b0, randSample(), 24'($urandom));
            end else begin
                for (int i = 0; i < TAPS; i++) begin fs[i] = randSample(); fc[i] = 24'($urandom); end
                sendFrame();
                idle($urandom_range(0, 1));
                step(1'b1, 1'b0, randSample(), 24'($urandom));
            end
        end
        // Close any open partial frame with a complete one, then drain.
        constFrame(24'sh100000, 24'sh200000);
        idle(10);

        check("outputs_outstanding", longint'(outQ.size()), 0);
        check("errors_outstanding", longint'(errQ.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_fir_tap_accumulator
